// File: rtl/agc_ram_pkg.sv
// Shared sizing constants and word/address types for the AGC sample RAM.
package agc_ram_pkg;

   localparam int AGC_RAM_DEPTH = 2048;
   localparam int AGC_RAM_AW    = 11;
   localparam int AGC_RAM_DW    = 15;

   typedef logic [AGC_RAM_AW-1:0] agc_addr_t;
   typedef logic [AGC_RAM_DW-1:0] agc_word_t;

endpackage

// File: rtl/agc_ram_if.sv
// Write/read port bundle of the AGC sample RAM; master drives, slave returns q.
interface agc_ram_if;
   import agc_ram_pkg::*;

   agc_word_t data;
   agc_addr_t wraddress;
   logic      wren;
   agc_addr_t rdaddress;
   logic      rden;
   logic      rd_addressstall;
   agc_word_t q;

   modport master (
      output data, wraddress, wren, rdaddress, rden, rd_addressstall,
      input  q
   );

   modport slave (
      input  data, wraddress, wren, rdaddress, rden, rd_addressstall,
      output q
   );

endinterface

// File: rtl/agc_ram_array.sv
// 2048 x 15 storage with a synchronous write port and an asynchronous read tap.
module agc_ram_array
   import agc_ram_pkg::*;
(
   input  logic      clock,
   input  logic      reset_n,
   input  logic      wren,
   input  agc_addr_t wraddress,
   input  agc_word_t data,
   input  agc_addr_t rd_addr,
   output agc_word_t rd_data
);

   // Contents start at zero and are deliberately outside the reset domain.
   agc_word_t mem [0:AGC_RAM_DEPTH-1] = '{default: '0};

   always_ff @(posedge clock) begin
      if (reset_n && wren) begin
         mem[wraddress] <= data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/agc_ram.sv
// AGC sample RAM top: read-address register, enable/stall gating and q register.
// Optional AGC_RAM_WR_BYPASS_EN returns same-edge write data on a colliding read.
module agc_ram
   import agc_ram_pkg::*;
(
   input  logic      clock,
   input  logic      reset_n,
   agc_ram_if.slave  bus
);

   logic      load;
   agc_addr_t rd_addr_q;
   agc_addr_t rd_addr_sel;
   agc_word_t rd_word;
   agc_word_t q_next;
   agc_word_t q_r;

   assign load = bus.rden && !bus.rd_addressstall;

   // Held address keeps the array tap stable while the read port is idle.
   assign rd_addr_sel = load ? bus.rdaddress : rd_addr_q;

   agc_ram_array u_array (
      .clock     (clock),
      .reset_n   (reset_n),
      .wren      (bus.wren),
      .wraddress (bus.wraddress),
      .data      (bus.data),
      .rd_addr   (rd_addr_sel),
      .rd_data   (rd_word)
   );

   always_comb begin
      q_next = rd_word;
`ifdef AGC_RAM_WR_BYPASS_EN
      if (bus.wren && (bus.wraddress == bus.rdaddress)) begin
         q_next = bus.data;
      end
`else
      // Collisions return the pre-write word; the array write lands at the same edge.
      q_next = rd_word;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr_q <= '0;
         q_r       <= '0;
      end else if (load) begin
         rd_addr_q <= bus.rdaddress;
         q_r       <= q_next;
      end
   end

   assign bus.q = q_r;

endmodule

// File: tb/tb_agc_ram.sv
// Directed-vector bench for agc_ram with hand-computed expected q values.
module tb_agc_ram;
   import agc_ram_pkg::*;

   logic clock;
   logic reset_n;
   int   n_vec;
   int   n_err;

`ifdef AGC_RAM_WR_BYPASS_EN
   localparam logic [14:0] COLLIDE_EXP = 15'h0555;
`else
   localparam logic [14:0] COLLIDE_EXP = 15'h0AAA;
`endif

   agc_ram_if bus ();

   agc_ram dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: q=%h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [10:0] a, input logic [14:0] d);
      bus.wren = 1'b1; bus.wraddress = a; bus.data = d;
      bus.rden = 1'b0;
      tick();
      bus.wren = 1'b0;
   endtask

   task automatic rd(input logic [10:0] a);
      bus.rden = 1'b1; bus.rdaddress = a; bus.rd_addressstall = 1'b0;
      tick();
      bus.rden = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      bus.data = '0; bus.wraddress = '0; bus.wren = 1'b0;
      bus.rdaddress = '0; bus.rden = 1'b0; bus.rd_addressstall = 1'b0;
      #2;
      chk("reset_q", bus.q, 15'h0000);

      // Write attempted under reset must be dropped.
      bus.wren = 1'b1; bus.wraddress = 11'd7; bus.data = 15'h3333;
      tick();
      tick();
      bus.wren = 1'b0;
      #2 reset_n = 1'b1;
      tick();
      rd(11'd7);
      chk("write_in_reset_ignored", bus.q, 15'h0000);

      // Basic write then read with one edge of latency.
      wr(11'd5, 15'h1234);
      chk("q_before_read", bus.q, 15'h0000);
      rd(11'd5);
      chk("rd_addr5", bus.q, 15'h1234);

      // Address extremes, no aliasing.
      wr(11'd2047, 15'h7FFF);
      wr(11'd0, 15'h0001);
      rd(11'd2047);
      chk("rd_addr2047", bus.q, 15'h7FFF);
      rd(11'd0);
      chk("rd_addr0", bus.q, 15'h0001);
      rd(11'd1023);
      chk("rd_addr1023_unwritten", bus.q, 15'h0000);
      rd(11'd1024);
      chk("rd_addr1024_unwritten", bus.q, 15'h0000);

      // Stall holds q for three edges, release loads the new address.
      rd(11'd5);
      chk("pre_stall", bus.q, 15'h1234);
      bus.rden = 1'b1; bus.rd_addressstall = 1'b1; bus.rdaddress = 11'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall_hold_%0d", i), bus.q, 15'h1234);
      end
      bus.rd_addressstall = 1'b0;
      tick();
      chk("stall_release", bus.q, 15'h0001);
      bus.rden = 1'b0;

      // Same-edge read/write collision.
      wr(11'd9, 15'h0AAA);
      bus.wren = 1'b1; bus.wraddress = 11'd9; bus.data = 15'h0555;
      bus.rden = 1'b1; bus.rdaddress = 11'd9;
      tick();
      bus.wren = 1'b0; bus.rden = 1'b0;
      chk("collide_rd", bus.q, COLLIDE_EXP);
      rd(11'd9);
      chk("collide_reread", bus.q, 15'h0555);

      // rden low: q holds whatever rdaddress does, even across writes.
      bus.rden = 1'b0;
      bus.rdaddress = 11'd0;    tick(); chk("hold_rden0_a", bus.q, 15'h0555);
      bus.rdaddress = 11'd2047; tick(); chk("hold_rden0_b", bus.q, 15'h0555);
      bus.wren = 1'b1; bus.wraddress = 11'd9; bus.data = 15'h0123; bus.rdaddress = 11'd9;
      tick();
      bus.wren = 1'b0;
      chk("hold_rden0_write", bus.q, 15'h0555);
      rd(11'd9);
      chk("write_while_idle", bus.q, 15'h0123);

      // Mid-stream reset clears q at once, drops writes, keeps memory.
      rd(11'd2047);
      chk("pre_reset", bus.q, 15'h7FFF);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_q", bus.q, 15'h0000);
      bus.wren = 1'b1; bus.wraddress = 11'd5; bus.data = 15'h0000;
      bus.rden = 1'b1; bus.rdaddress = 11'd2047;
      tick();
      tick();
      chk("reset_hold_q", bus.q, 15'h0000);
      bus.wren = 1'b0; bus.rden = 1'b0;
      #2 reset_n = 1'b1;
      rd(11'd5);
      chk("retained_after_reset", bus.q, 15'h1234);
      wr(11'd100, 15'h0F0F);
      rd(11'd100);
      chk("write_after_reset", bus.q, 15'h0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
